// File: rtl/control_param_encoder.sv
// control_param_encoder: readback transmitter for the control-parameter
// register set. Serialises the large/small register buses into
// {code, pad, payload} words on a valid/ready stream, either as a
// header-framed full dump or as a single register read by code.
module control_param_encoder #(
  parameter int N_LARGE = 2,
  parameter logic [(N_LARGE+1)*32-1:0] LARGE_REG_START_IDXS = {32'd64, 32'd32, 32'd0},
  parameter int N_SMALL = 4,
  parameter logic [(N_SMALL+1)*32-1:0] SMALL_REG_START_IDXS =
    {32'd64, 32'd48, 32'd32, 32'd16, 32'd0},
  parameter int MAX_TRANSMISSION_SIZE = 16,
  localparam int LTOT = int'(LARGE_REG_START_IDXS[N_LARGE*32 +: 32]),
  localparam int STOT = int'(SMALL_REG_START_IDXS[N_SMALL*32 +: 32])
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [LTOT-1:0] large_regs,
  input  logic [STOT-1:0] small_regs,
  input  logic            dump_req,
  input  logic            single_req,
  input  logic [7:0]      single_code,
  output logic [31:0]     tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int PW = MAX_TRANSMISSION_SIZE;
  localparam int NW = 2*N_LARGE + N_SMALL;

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_SEND, S_DONE} state_t;

  state_t          state;
  logic [7:0]      cnt;
  logic            single_rd;
  logic [LTOT-1:0] large_sh;
  logic [STOT-1:0] small_sh;

  // Source 0 is the live bus (used only for the first word of a single
  // read, loaded on the same edge the snapshot is taken); source 1 is the
  // shadow copy that every later word is built from.
  logic [1:0][LTOT-1:0]     lsrc;
  logic [1:0][STOT-1:0]     ssrc;
  logic [1:0][NW:0][PW-1:0] pay;

  assign lsrc[0] = large_regs;
  assign lsrc[1] = large_sh;
  assign ssrc[0] = small_regs;
  assign ssrc[1] = small_sh;

  for (genvar s = 0; s < 2; s++) begin : g_src
    // code 0 is the header, whose payload is the word count
    assign pay[s][0] = PW'(NW);

    for (genvar i = 0; i < N_LARGE; i++) begin : g_large
      localparam int LS = int'(LARGE_REG_START_IDXS[i*32 +: 32]);
      localparam int LW = int'(LARGE_REG_START_IDXS[(i+1)*32 +: 32]) - LS;
      localparam logic [31:0] LMASK = (LW >= 32) ? 32'hFFFF_FFFF : ((32'd1 << LW) - 32'd1);
      logic [31:0] r;
      assign r = 32'(lsrc[s] >> LS) & LMASK;
      // odd code: upper bits right-aligned, even code: low 16 bits
      assign pay[s][2*i+1] = PW'(r >> 16);
      assign pay[s][2*i+2] = PW'(r[15:0]);
    end

    for (genvar j = 0; j < N_SMALL; j++) begin : g_small
      localparam int SS = int'(SMALL_REG_START_IDXS[j*32 +: 32]);
      localparam int SW = int'(SMALL_REG_START_IDXS[(j+1)*32 +: 32]) - SS;
      localparam logic [15:0] SMASK = (SW >= 16) ? 16'hFFFF : ((16'd1 << SW) - 16'd1);
      assign pay[s][2*N_LARGE+1+j] = PW'(16'(ssrc[s] >> SS) & SMASK);
    end
  end

  logic [7:0]    nxt_code;
  logic [PW-1:0] nxt_pay;
  logic          code_ok;
  logic          last_word;

  assign code_ok   = (single_code != 8'd0) && (single_code <= 8'(NW));
  assign last_word = (cnt == 8'(NW)) || single_rd;

  // Word that will be presented after the next load: the requested code
  // when idle, the first data word after the header, else the next code.
  always_comb begin
    nxt_code = cnt;
    nxt_pay  = '0;
    case (state)
      S_IDLE:   nxt_code = single_code;
      S_HEADER: nxt_code = cnt;
      S_SEND:   nxt_code = cnt + 8'd1;
      default:  nxt_code = cnt;
    endcase
    for (int k = 0; k <= NW; k++)
      if (nxt_code == 8'(k)) nxt_pay = pay[(state == S_IDLE) ? 1'b0 : 1'b1][k];
  end

  assign busy = (state != S_IDLE);

  // Control FSM with registered stream outputs and one-cycle pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      single_rd <= 1'b0;
      large_sh  <= '0;
      small_sh  <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          // dump wins over a simultaneous single request
          if (dump_req) begin
            large_sh  <= large_regs;
            small_sh  <= small_regs;
            cnt       <= 8'd1;
            single_rd <= 1'b0;
            tx_data   <= {8'd0, 24'(pay[0][0])};
            tx_valid  <= 1'b1;
            state     <= S_HEADER;
          end else if (single_req) begin
            if (code_ok) begin
              large_sh  <= large_regs;
              small_sh  <= small_regs;
              cnt       <= single_code;
              single_rd <= 1'b1;
              tx_data   <= {nxt_code, 24'(nxt_pay)};
              tx_valid  <= 1'b1;
              state     <= S_SEND;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_HEADER: begin
          if (tx_ready) begin
            tx_data <= {nxt_code, 24'(nxt_pay)};
            state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (tx_ready) begin
            if (last_word) begin
              tx_data  <= '0;
              tx_valid <= 1'b0;
              done     <= 1'b1;
              state    <= S_DONE;
            end else begin
              cnt     <= cnt + 8'd1;
              tx_data <= {nxt_code, 24'(nxt_pay)};
            end
          end
        end
        default: begin
          single_rd <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/control_param_encoder.md
# control_param_encoder

Readback transmitter for the control-parameter register set: serialises the large and small control registers into the same 32-bit `{code, pad, payload}` word format used on the host-to-FPGA write path. Words go to the host link through a valid/ready stream. Supports a full coherent dump, framed by a header word, and a single-register read by code. Sits beside the parameter decoder, taking its register buses as inputs, and feeds the transmit FIFO/serialiser.

## Interface
- `LARGE_REG_START_IDXS`, default `{64, 32, 0}`: packed 32-bit bit-offsets into `large_regs`. Entry i is at bits [(i+1)*32-1 -: 32]. Entry N_LARGE is the total width.
- `N_LARGE`, default 2: number of large registers. Each is 17..32 bits wide.
- `SMALL_REG_START_IDXS`, default `{64, 48, 32, 16, 0}`: packed offsets into `small_regs`, in the same layout.
- `N_SMALL`, default 4: number of small registers. Each is 1..16 bits wide.
- `MAX_TRANSMISSION_SIZE`, default 16: payload width per word.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `large_regs` in LARGE_REG_START_IDXS[N_LARGE]: live large-register bus.
- `small_regs` in SMALL_REG_START_IDXS[N_SMALL]: live small-register bus.
- `dump_req` in 1: one-cycle pulse that requests a full dump.
- `single_req` in 1: one-cycle pulse that requests a single read.
- `single_code` in 8: register code for the single read. Sampled together with `single_req`.
- `tx_data` out 32: output word.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: downstream accepts the word.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a dump or single read completes.
- `err` out 1: one-cycle pulse when `single_code` is invalid.

## Operation
- **Word format:** [31:24] = code, [23:16] = 0, [15:0] = payload. The payload is zero-extended.
- **Codes:**
  - Large register i has width W = start(i+1) - start(i).
    - Code 2i+1 (MSB word) carries bits [W-1:16], right-aligned.
    - Code 2i+2 (LSB word) carries bits [15:0].
  - Small register j: code 2·N_LARGE+1+j carries the full register.
  - N_WORDS = 2·N_LARGE + N_SMALL. Valid codes are 1..N_WORDS.
- **Header:** code 0, payload = N_WORDS. Emitted only for dumps.
- **Snapshot:** on request acceptance, both register buses are captured into shadow registers. All emitted words come from the shadow copy, so a dump is coherent even if the buses change mid-dump.
- **States:**
  - IDLE: accept requests.
  - HEADER: present the header word.
  - SEND: present the word for the current code.
  - DONE: pulse `done`, then return to IDLE.
- **Transitions:**
  - IDLE + `dump_req` → HEADER, with code counter = 1.
  - IDLE + `single_req` with a valid code → SEND, with counter = code and a single-read flag set.
  - IDLE + `single_req` with an invalid code (0 or > N_WORDS) → pulse `err`, stay in IDLE, emit no word.
  - HEADER, on handshake → SEND.
  - SEND, on handshake: if counter = N_WORDS or the single-read flag is set → DONE; otherwise counter + 1.
  - DONE → IDLE.
- **Simultaneous requests:** `dump_req` and `single_req` together → the dump wins and the single request is dropped.
- **Requests while busy** are ignored. They are not queued.

## Timing
- **Reset values:** `tx_valid`=0, `tx_data`=0, `busy`=0, `done`=0, `err`=0. State = IDLE, shadows = 0.
- **Async reset mid-frame:** aborts immediately. No `done` pulse; the frame is truncated.
- **Request latency:** request sampled at edge t → `tx_valid`=1 with the first word during cycle t+1. `err` is likewise high during cycle t+1 only.
- **Handshake:** a transfer occurs at an edge where `tx_valid` && `tx_ready`.
  - While `tx_valid` && !`tx_ready`, `tx_data` and `tx_valid` hold stable.
  - After a transfer, the next word is valid in the very next cycle. Throughput is 1 word/cycle with `tx_ready` held high.
- **Dump length:** with `tx_ready` held high, a dump is N_WORDS+1 consecutive valid cycles. `done` is high for one cycle immediately after the last transfer, with `tx_valid`=0 in that cycle. `busy` falls in the cycle after `done`.
- **Single read:** 1 valid cycle, then `done`.
- **`tx_ready` behaviour:** `tx_ready` low for any number of cycles stalls the frame with no word lost or duplicated. `tx_ready` high while `tx_valid` is low has no effect.

## Test plan
- **Full dump:**
  - Stimulus: `large_regs`=64'hDEADBEEF_12345678, `small_regs`=64'h4444_3333_2222_1111, `tx_ready`=1, `dump_req` pulse.
  - Required: 00000008, 01001234, 02005678, 0300DEAD, 0400BEEF, 05001111, 06002222, 07003333, 08004444 on consecutive cycles; `done` on the next cycle.
- **Coherence:** same dump, but change both buses to all-ones one cycle after `dump_req`. All nine words must be unchanged.
- **Backpressure:** toggle `tx_ready` pseudo-randomly during a dump. The accepted sequence must be identical to the full-dump case; `tx_data` must be stable whenever it is stalled.
- **Single read:**
  - `single_code`=3 → a single word 0300DEAD, then `done`, with no header.
  - `single_code`=0 or 9 → `err` pulse, no `tx_valid`, no `done`.
- **Collisions:** `dump_req` and `single_req` together → full dump only. A second `dump_req` in mid-frame → ignored; exactly 9 words are sent.
- **Reset mid-dump:** assert `reset_n`=0 after the 4th transfer. All outputs go to 0 immediately with no `done`. After release, a new `dump_req` produces a full 9-word frame.
